bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the PL local register bus (baddr/bwrdata/bwr/bstrobe/brddata).
- Sits between the AXI-lite bridge, which is requester 0, and a second bus master such as a DMA/sequencer, which is requester 1. It drives the single local bus into the register block.
- Serialises transactions, generates a one-cycle bstrobe, waits a fixed read latency, and returns read data with an ack pulse.

Parameters:
RD_LATENCY, 2, number of WAIT cycles between the bstrobe cycle and brddata capture; legal range 0..15.
ADDR_W, 16, local bus address width.
DATA_W, 16, local bus data width.

Ports:
- clk  in  1  PL clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 transaction request, level.
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wr  in  1  requester 0: 1=write, 0=read.
- r0_wrdata  in  DATA_W  requester 0 write data.
- r0_ack  out  1  requester 0 completion pulse.
- r0_rddata  out  DATA_W  requester 0 read data.
- r1_req, r1_addr, r1_wr, r1_wrdata, r1_ack, r1_rddata: same as the r0_* ports, for requester 1.
- baddr  out  ADDR_W  local bus address.
- bwrdata  out  DATA_W  local bus write data.
- bwr  out  1  local bus write enable; qualified by bstrobe.
- bstrobe  out  1  local bus strobe, one cycle per transaction.
- brddata  in  DATA_W  local bus read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (so r0 wins the first tie). A reset mid-transaction aborts it and no ack is issued.
- Requester protocol:
  - The requester holds req/addr/wr/wrdata stable from req assertion until it sees ack.
  - It must deassert req, or present a new transaction, by the edge after ack=1.
  - Addr/wr/wrdata are latched at grant, so later changes are ignored.
- State machine, all outputs registered:
  - IDLE: if no req, stay. If exactly one req, grant it. If both req, grant the requester != last_grant. Latch addr/wr/wrdata and grant id, then go to STROBE.
  - STROBE, 1 cycle: bstrobe=1, bwr=latched wr, baddr/bwrdata=latched values. Go to WAIT if RD_LATENCY>0, else to ACK.
  - WAIT, RD_LATENCY cycles: bstrobe=0, bwr=0, counter counts down.
  - ACK, 1 cycle: brddata is captured into the granted requester's rddata on the edge entering ACK. That requester's ack=1. last_grant is updated to the granted id. Go to GAP.
  - GAP, 1 cycle: no grant taken, which lets registered requesters drop req. Go to IDLE.
- Timing: req seen at edge 0 gives bstrobe in cycle 1, ack in cycle 2+RD_LATENCY, and next possible bstrobe in cycle 5+RD_LATENCY. Reads and writes have identical timing; on writes, rddata is still updated with whatever brddata shows.
- bwr and bstrobe are 0 outside STROBE. baddr/bwrdata hold their last latched values.
- rN_rddata holds its value until that requester's next ack. The other requester's rddata is unchanged.
- Simultaneous events:
  - A req arriving during a transaction waits; the no-starvation guarantee is strict alternation under continuous contention.
  - A req that drops before grant is simply not served.
- The RD_LATENCY counter is 4 bits. No wrap occurs within the legal range.

Optional Feature:
- Macro BUS_ARBITER_STATS_EN.
- Defined: adds output ports r0_grants and r1_grants (16 bits each). Each increments on its requester's ack and wraps 0xFFFF->0x0000. Both reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package bus_arbiter_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, ACK, GAP);
  - the ADDR_W/DATA_W default constants;
  - the grant-id type (1 bit).
- One sub-module, bus_arbiter_rr2: a combinational two-way round-robin picker with inputs req[1:0] and last_grant, and outputs gnt_valid and gnt_id.

Test Plan:
- r0 read, addr 0x0012, brddata=0xBEEF, RD_LATENCY=2 -> bstrobe=1, bwr=0, baddr=0x0012 in cycle 1; r0_ack in cycle 4; r0_rddata=0xBEEF; r1_ack stays 0.
- r1 write, addr 0x0034, wrdata 0x5A5A -> exactly one bstrobe cycle with bwr=1, bwrdata=0x5A5A; r1_ack 3 cycles later; busy high for 5 cycles.
- r0 and r1 requesting continuously from reset, 6 transactions -> grant order r0,r1,r0,r1,r0,r1; no overlapping bstrobe.
- r0 changes addr from 0x0001 to 0x00FF after grant -> bus still shows 0x0001.
- rst asserted during WAIT -> all outputs go to 0 immediately; no ack; after release, a new r1 read completes normally.
- BUS_ARBITER_STATS_EN defined, 0x10000 r0 acks plus 3 r1 acks -> r0_grants=0x0000 (wrapped), r1_grants=0x0003.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester local-bus arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef logic gid_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    WAIT   = 3'd2,
    ACK    = 3'd3,
    GAP    = 3'd4
  } state_t;

  // Counter preload on leaving STROBE; WAIT exits when the count reaches zero.
  function automatic logic [CNT_W-1:0] wait_init(input int lat);
    if (lat > 0) return CNT_W'(lat - 1);
    return '0;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr2.sv
// Combinational two-way round-robin picker: a lone request wins, a tie goes
// to the requester that was not served last.
module bus_arbiter_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer driving the PL local register bus.
// Optional grant counters r0_grants/r1_grants when BUS_ARBITER_STATS_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_wr,
  input  logic [DATA_W-1:0] r0_wrdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rddata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_wr,
  input  logic [DATA_W-1:0] r1_wrdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rddata,
  output logic [ADDR_W-1:0] baddr,
  output logic [DATA_W-1:0] bwrdata,
  output logic              bwr,
  output logic              bstrobe,
  input  logic [DATA_W-1:0] brddata,
  output logic              busy
`ifdef BUS_ARBITER_STATS_EN
  ,
  output logic [15:0]       r0_grants,
  output logic [15:0]       r1_grants
`endif
);

  localparam logic [CNT_W-1:0] WAIT_INIT = wait_init(RD_LATENCY);

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt;
  gid_t                    gid, last_grant, gnt_id;
  logic                    gnt_valid, take;
  logic                    strobe_d, busy_d, enter_ack;
  logic [1:0]              req, req_wr, hit;
  logic [1:0][ADDR_W-1:0]  req_addr;
  logic [1:0][DATA_W-1:0]  req_wrdata;
  logic [1:0]              ack;
  logic [1:0][DATA_W-1:0]  rddata;

  assign req        = {r1_req, r0_req};
  assign req_wr     = {r1_wr, r0_wr};
  assign req_addr   = {r1_addr, r0_addr};
  assign req_wrdata = {r1_wrdata, r0_wrdata};

  bus_arbiter_rr2 u_rr2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign take = (state == IDLE) && gnt_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (gnt_valid) state_d = STROBE;
      STROBE:  state_d = (RD_LATENCY > 0) ? WAIT : ACK;
      WAIT:    if (cnt == '0) state_d = ACK;
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every port is a flop.
  always_comb begin
    strobe_d  = (state_d == STROBE);
    busy_d    = (state_d != IDLE);
    enter_ack = (state_d == ACK);
    hit       = {enter_ack & gid, enter_ack & ~gid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (state == STROBE)         cnt <= WAIT_INIT;
    else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bstrobe    <= 1'b0;
      bwr        <= 1'b0;
      busy       <= 1'b0;
      baddr      <= '0;
      bwrdata    <= '0;
      gid        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      bstrobe <= strobe_d;
      bwr     <= strobe_d & req_wr[gnt_id];
      busy    <= busy_d;
      if (take) begin
        baddr   <= req_addr[gnt_id];
        bwrdata <= req_wrdata[gnt_id];
        gid     <= gnt_id;
      end
      if (enter_ack) last_grant <= gid;
    end
  end

  // Only the served requester's read data moves; the other keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack    <= '0;
      rddata <= '0;
    end else begin
      ack <= hit;
      for (int i = 0; i < 2; i++)
        if (hit[i]) rddata[i] <= brddata;
    end
  end

  assign r0_ack    = ack[0];
  assign r1_ack    = ack[1];
  assign r0_rddata = rddata[0];
  assign r1_rddata = rddata[1];

`ifdef BUS_ARBITER_STATS_EN
  logic [1:0][15:0] grants;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grants <= '0;
    else
      for (int i = 0; i < 2; i++)
        if (hit[i]) grants[i] <= grants[i] + 16'd1;
  end

  assign r0_grants = grants[0];
  assign r1_grants = grants[1];
`endif

endmodule
